// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: request side (in_*) and result side (out_*).
// The slave modport is the extender; the master modport is the surrounding logic.
interface ext_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [2:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic              out_illegal;

  modport master (
    output in_valid, in_imm, in_op, out_ready,
    input  in_ready, out_valid, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_imm, in_op, out_ready,
    output in_ready, out_valid, out_imm, out_illegal
  );
endinterface

// File: rtl/ext_pipe.sv
// Immediate extender behind a two-entry (output + skid) registered pipe.
// Optional macro EXT_BRANCH_OFFSET_EN enables in_op 4 (branch offset); otherwise op 4 is illegal.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  ext_pipe_if.slave  bus,
  output logic [7:0] illegal_cnt
);
  localparam int EXT_W = DATA_W - IMM_W;

  // Returns {illegal, extended value}.
  function automatic logic [DATA_W:0] ext_f(input logic [IMM_W-1:0] imm, input logic [2:0] op);
    logic [DATA_W-1:0] v_sext;
    logic [DATA_W:0]   v_res;
    v_sext = {{EXT_W{imm[IMM_W-1]}}, imm};
    case (op)
      3'd0:    v_res = {1'b0, {EXT_W{1'b0}}, imm};
      3'd1:    v_res = {1'b0, v_sext};
      3'd2:    v_res = {1'b0, {(DATA_W-5){1'b0}}, imm[10:6]};
      3'd3:    v_res = {1'b0, imm, {EXT_W{1'b0}}};
`ifdef EXT_BRANCH_OFFSET_EN
      3'd4:    v_res = {1'b0, v_sext[DATA_W-3:0], 2'b00};
`else
      3'd4:    v_res = {1'b1, {DATA_W{1'b0}}};
`endif
      default: v_res = {1'b1, {DATA_W{1'b0}}};
    endcase
    return v_res;
  endfunction

  logic              r_o_valid;
  logic [DATA_W-1:0] r_o_imm;
  logic              r_o_ill;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_imm;
  logic              r_s_ill;
  logic              r_in_ready;
  logic [7:0]        r_cnt;

  logic              w_acc;
  logic              w_o_free;
  logic              w_s_valid_nx;
  logic [DATA_W:0]   w_ext;

  assign w_acc    = bus.in_valid && r_in_ready;
  assign w_o_free = !r_o_valid || bus.out_ready;
  assign w_ext    = ext_f(bus.in_imm, bus.in_op);

  // Skid occupancy after this edge; drives the registered in_ready.
  always_comb begin
    w_s_valid_nx = r_s_valid;
    if (w_o_free) begin
      w_s_valid_nx = r_s_valid && w_acc;
    end else begin
      w_s_valid_nx = r_s_valid || w_acc;
    end
  end

  // Output/skid register pair: O refills from S first so ordering stays FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_valid  <= 1'b0;
      r_o_imm    <= {DATA_W{1'b0}};
      r_o_ill    <= 1'b0;
      r_s_valid  <= 1'b0;
      r_s_imm    <= {DATA_W{1'b0}};
      r_s_ill    <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_o_free) begin
        if (r_s_valid) begin
          r_o_valid <= 1'b1;
          r_o_imm   <= r_s_imm;
          r_o_ill   <= r_s_ill;
          if (w_acc) begin
            r_s_imm <= w_ext[DATA_W-1:0];
            r_s_ill <= w_ext[DATA_W];
          end
        end else if (w_acc) begin
          r_o_valid <= 1'b1;
          r_o_imm   <= w_ext[DATA_W-1:0];
          r_o_ill   <= w_ext[DATA_W];
        end else begin
          r_o_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_s_imm <= w_ext[DATA_W-1:0];
        r_s_ill <= w_ext[DATA_W];
      end
      r_s_valid  <= w_s_valid_nx;
      r_in_ready <= !w_s_valid_nx;
    end
  end

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_acc && w_ext[DATA_W] && (r_cnt != 8'd255)) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_o_valid;
  assign bus.out_imm     = r_o_imm;
  assign bus.out_illegal = r_o_ill;
  assign illegal_cnt     = r_cnt;
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IMM_W, default 16, immediate field width; SHALL satisfy 11 <= IMM_W.
REQ-002 Parameter DATA_W, default 32, extended result width; SHALL satisfy DATA_W >= IMM_W+2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block can accept; registered signal.
REQ-007 in_imm  input  IMM_W  raw immediate field.
REQ-008 in_op  input  3  extension mode select.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_imm  output  DATA_W  extended result.
REQ-012 out_illegal  output  1  result came from unsupported in_op; qualified by out_valid.
REQ-013 illegal_cnt  output  8  count of accepted illegal ops.

Function
REQ-014 Input accepted on a cycle where in_valid && in_ready; output consumed where out_valid && out_ready.
REQ-015 in_op 0: zero-extend, out_imm = {zeros, in_imm}.
REQ-016 in_op 1: sign-extend, replicate in_imm[IMM_W-1] into upper DATA_W-IMM_W bits.
REQ-017 in_op 2: shift amount, out_imm = zero-extended in_imm[10:6].
REQ-018 in_op 3: upper load, out_imm = {in_imm, DATA_W-IMM_W zeros}.
REQ-019 in_op 4: branch offset, sign-extended in_imm shifted left 2, bits above DATA_W dropped (see REQ-031).
REQ-020 in_op 5..7: illegal; out_imm = 0, out_illegal = 1; all legal ops give out_illegal = 0.
REQ-021 Storage: one output register (O) plus one skid register (S), each with own valid bit.
REQ-022 Latency: accepted input appears in O the next cycle when O is empty or being consumed; no combinational path in->out.
REQ-023 On accept: if O empty or consumed this cycle and S empty, result loads O; if O full and not consumed, result loads S.
REQ-024 When O is consumed and S valid, S moves into O the same edge and S empties; a simultaneous accept then loads S.
REQ-025 in_ready = !S.valid, registered; accept never overwrites valid data.
REQ-026 Sustained throughput one result per cycle while out_ready = 1; ordering strictly FIFO.
REQ-027 out_valid, out_imm, out_illegal stable while out_valid && !out_ready.
REQ-028 illegal_cnt increments by 1 per accepted illegal op, saturates at 255, never wraps.

Reset
REQ-029 On rst: O.valid = 0, S.valid = 0, out_valid = 0, in_ready = 1, out_imm = 0, out_illegal = 0, illegal_cnt = 0.
REQ-030 rst mid-transfer discards O and S contents; no accept or consume takes effect in a reset cycle.

Configuration
REQ-031 Macro EXT_BRANCH_OFFSET_EN: defined -> in_op 4 per REQ-019; undefined -> in_op 4 treated as illegal per REQ-020 and counted in illegal_cnt.

Verification
REQ-032 IMM_W=16, DATA_W=32, out_ready=1; in_op 1, in_imm 16'h8001 -> next cycle out_valid=1, out_imm 32'hFFFF8001, out_illegal=0.
REQ-033 in_op 2, in_imm 16'h07C0 -> out_imm 32'h0000001F; in_op 3, in_imm 16'h1234 -> out_imm 32'h12340000.
REQ-034 Macro defined, in_op 4, in_imm 16'hFFFF -> out_imm 32'hFFFFFFFC; macro undefined -> out_imm 0, out_illegal=1, illegal_cnt=1.
REQ-035 Back-to-back 3 accepts with out_ready=0 -> O and S fill, in_ready=0 after 2nd accept, 3rd held; release out_ready -> results in order A,B,C, no loss or duplicate.
REQ-036 300 accepted in_op 7 -> illegal_cnt reaches and holds 255.
REQ-037 Assert rst with O and S full -> following cycle out_valid=0, in_ready=1, illegal_cnt=0.
